// File: rtl/wash_seq_ctrl.sv
// Washing-machine phase sequencer: IDLE -> WASH -> RINSE -> SPIN -> DONE -> IDLE.
// Optional duty soft-start ramp enabled by defining WASH_SOFT_START_EN.
module wash_seq_ctrl #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned WASH_TICKS  = 3000,
  parameter int unsigned RINSE_TICKS = 2000,
  parameter int unsigned SPIN_TICKS  = 4000
) (
  input  logic        sysclk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  output logic [1:0]  o_pwm_duty,
  output logic [2:0]  o_state,
  output logic [13:0] o_remain,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WASH  = 3'd1;
  localparam logic [2:0] ST_RINSE = 3'd2;
  localparam logic [2:0] ST_SPIN  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned       PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [13:0]       WASH_LEN  = 14'(WASH_TICKS);
  localparam logic [13:0]       RINSE_LEN = 14'(RINSE_TICKS);
  localparam logic [13:0]       SPIN_LEN  = 14'(SPIN_TICKS);

  logic [2:0]    state_q, state_d;
  logic [1:0]    duty_q, duty_d;
  logic [13:0]   remain_q, remain_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          start_prev_q, start_prev_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          start_edge;
  logic          tick;
  logic [1:0]    target;

  function automatic logic [1:0] duty_target(input logic [2:0] st);
    case (st)
      ST_WASH:  duty_target = 2'd1;
      ST_RINSE: duty_target = 2'd2;
      ST_SPIN:  duty_target = 2'd3;
      default:  duty_target = 2'd0;
    endcase
  endfunction

  function automatic logic is_run(input logic [2:0] st);
    is_run = (st == ST_WASH) || (st == ST_RINSE) || (st == ST_SPIN);
  endfunction

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    presc_d      = presc_q;
    start_prev_d = i_start;
    start_edge   = i_start && !start_prev_q;
    tick         = busy_q && (presc_q == PRESC_MAX);

    if (i_stop) begin
      state_d  = ST_IDLE;
      remain_d = '0;
      presc_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_d  = ST_WASH;
            remain_d = WASH_LEN;
            presc_d  = '0;
          end
        end
        ST_WASH, ST_RINSE, ST_SPIN: begin
          if (tick) begin
            presc_d = '0;
            if (remain_q == 14'd1) begin
              case (state_q)
                ST_WASH:  begin state_d = ST_RINSE; remain_d = RINSE_LEN; end
                ST_RINSE: begin state_d = ST_SPIN;  remain_d = SPIN_LEN;  end
                default:  begin state_d = ST_DONE;  remain_d = '0;        end
              endcase
            end else if (remain_q != '0) begin
              remain_d = remain_q - 14'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d  = ST_IDLE;
          remain_d = '0;
          presc_d  = '0;
        end
      endcase
    end

    busy_d = is_run(state_d);
    done_d = (state_d == ST_DONE);
    target = duty_target(state_d);

`ifdef WASH_SOFT_START_EN
    // A phase entry keeps the running duty (at least 1) and climbs one step per tick;
    // anything above the new target drops straight to it.
    duty_d = duty_q;
    if (!busy_d) begin
      duty_d = '0;
    end else if (state_d != state_q) begin
      duty_d = (duty_q == '0) ? 2'd1 : duty_q;
      if (duty_d > target) duty_d = target;
    end else if (tick && (duty_q < target)) begin
      duty_d = duty_q + 2'd1;
    end else if (duty_q > target) begin
      duty_d = target;
    end
`else
    duty_d = target;
`endif
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      duty_q       <= '0;
      remain_q     <= '0;
      presc_q      <= '0;
      start_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      remain_q     <= remain_d;
      presc_q      <= presc_d;
      start_prev_q <= start_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_state    = state_q;
  assign o_pwm_duty = duty_q;
  assign o_remain   = remain_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Self-checking bench for wash_seq_ctrl: directed scenarios plus random start/stop
// traffic, compared against a phase/elapsed-cycle reference model.
module tb_wash_seq_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned WT = 3;
  localparam int unsigned RT = 2;
  localparam int unsigned ST = 2;

  logic        sysclk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_stop;
  logic [1:0]  o_pwm_duty;
  logic [2:0]  o_state;
  logic [13:0] o_remain;
  logic        o_busy;
  logic        o_done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // reference model: phase 0 idle, 1..3 running, 4 done; elapsed cycles within phase
  int unsigned m_phase   = 0;
  int unsigned m_elapsed = 0;
  int unsigned m_duty    = 0;
  bit          m_prev    = 1'b0;

  wash_seq_ctrl #(
    .TICK_DIV   (TD),
    .WASH_TICKS (WT),
    .RINSE_TICKS(RT),
    .SPIN_TICKS (ST)
  ) dut (
    .sysclk    (sysclk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .o_pwm_duty(o_pwm_duty),
    .o_state   (o_state),
    .o_remain  (o_remain),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int unsigned phase_ticks(input int unsigned p);
    case (p)
      1:       return WT;
      2:       return RT;
      3:       return ST;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned phase_target(input int unsigned p);
    return (p >= 1 && p <= 3) ? p : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_duty = 0; m_prev = 1'b0;
  endtask

  task automatic model_clock(input bit start, input bit stop);
    int unsigned old_phase;
    bit          rise;
    old_phase = m_phase;
    rise      = start && !m_prev;
    m_prev    = start;
    if (stop) begin
      m_phase = 0; m_elapsed = 0;
    end else begin
      case (m_phase)
        0: if (rise) begin m_phase = 1; m_elapsed = 0; end
        1, 2, 3: begin
          m_elapsed++;
          if (m_elapsed == phase_ticks(m_phase) * TD) begin
            m_phase++;
            m_elapsed = 0;
          end
        end
        default: begin m_phase = 0; m_elapsed = 0; end
      endcase
    end
`ifdef WASH_SOFT_START_EN
    if (m_phase < 1 || m_phase > 3) m_duty = 0;
    else if (m_phase != old_phase) begin
      if (m_duty == 0) m_duty = 1;
      if (m_duty > phase_target(m_phase)) m_duty = phase_target(m_phase);
    end else if (m_elapsed % TD == 0 && m_duty < phase_target(m_phase)) m_duty++;
`else
    m_duty = phase_target(m_phase);
`endif
  endtask

  function automatic int unsigned m_remain();
    if (m_phase >= 1 && m_phase <= 3) return phase_ticks(m_phase) - m_elapsed / TD;
    return 0;
  endfunction

  task automatic compare_all();
    check("state",  32'(o_state),    32'(m_phase));
    check("duty",   32'(o_pwm_duty), 32'(m_duty));
    check("remain", 32'(o_remain),   32'(m_remain()));
    check("busy",   32'(o_busy),     32'(m_phase >= 1 && m_phase <= 3));
    check("done",   32'(o_done),     32'(m_phase == 4));
  endtask

  // drive one cycle's inputs, clock it, then compare at the following negedge
  task automatic step(input bit start, input bit stop);
    i_start = start;
    i_stop  = stop;
    @(posedge sysclk);
    model_clock(start, stop);
    @(negedge sysclk);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"},  32'(o_state),    0);
    check({tag, "_duty"},   32'(o_pwm_duty), 0);
    check({tag, "_remain"}, 32'(o_remain),   0);
    check({tag, "_busy"},   32'(o_busy),     0);
    check({tag, "_done"},   32'(o_done),     0);
  endtask

  initial begin
    int unsigned done_cycle;
    int unsigned done_cnt;
    int unsigned run_cnt;
    bit          busy_prev;

    i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    model_reset();
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check_zero("reset");
    i_rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    // full run: start pulse in cycle 0
    done_cycle = 0;
    for (int unsigned k = 0; k <= 30; k++) begin
      step(k == 0, 1'b0);
      if (o_done && done_cycle == 0) done_cycle = k + 1;
      if (k + 1 == 1)  check("wash_entry_remain", 32'(o_remain), WT);
      if (k + 1 == 13) check("rinse_entry_state", 32'(o_state), 2);
      if (k + 1 == 21) check("spin_entry_state", 32'(o_state), 3);
    end
    check("done_cycle", done_cycle, 29);
    check("idle_after_done", 32'(o_state), 0);

    // abort during RINSE
    done_cnt = 0;
    for (int unsigned k = 0; k <= 20; k++) begin
      step(k == 0, k == 15);
      if (o_done) done_cnt++;
      if (k + 1 == 16) check_zero("abort");
    end
    check("abort_no_done", done_cnt, 0);

    // start held high through a whole run and beyond
    done_cnt = 0; run_cnt = 0; busy_prev = 1'b0;
    for (int unsigned k = 0; k <= 40; k++) begin
      step(1'b1, 1'b0);
      if (o_done) done_cnt++;
      if (o_busy && !busy_prev) run_cnt++;
      busy_prev = o_busy;
    end
    check("held_done_count", done_cnt, 1);
    check("held_run_count", run_cnt, 1);
    step(1'b0, 1'b0);

    // start and stop together
    step(1'b1, 1'b1);
    check("start_stop_idle", 32'(o_state), 0);
    step(1'b0, 1'b0);

    // asynchronous reset during SPIN (cycle 22)
    for (int unsigned k = 0; k <= 21; k++) step(k == 0, 1'b0);
    check("pre_reset_spin", 32'(o_state), 3);
    #2 i_rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge sysclk);
    @(negedge sysclk);
    i_rst_n = 1'b1;
    for (int unsigned k = 0; k < 6; k++) step(1'b0, 1'b0);
    check("post_reset_idle", 32'(o_state), 0);
    step(1'b1, 1'b0);
    check("restart_after_reset", 32'(o_state), 1);

    // random start/stop traffic
    for (int unsigned k = 0; k < 600; k++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wash_seq_ctrl.md
WASH_SEQ_CTRL -- requirements
Module: wash_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, sysclk cycles per phase tick (1 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter WASH_TICKS, default 3000, wash phase length in ticks; legal range 1..16383.
REQ-003 Parameter RINSE_TICKS, default 2000, rinse phase length in ticks; legal range 1..16383.
REQ-004 Parameter SPIN_TICKS, default 4000, spin phase length in ticks; legal range 1..16383.
REQ-005 sysclk  input  1  single system clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_start  input  1  start request, level, synchronous to sysclk; acted on at its rising edge only.
REQ-008 i_stop  input  1  abort request, level, synchronous; acted on whenever high.
REQ-009 o_pwm_duty  output  2  duty code to PWM generator: 0 off, 1 low, 2 mid, 3 high.
REQ-010 o_state  output  3  current phase: 0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DONE.
REQ-011 o_remain  output  14  ticks remaining in current phase; 14-bit FND data.
REQ-012 o_busy  output  1  high in WASH, RINSE, SPIN.
REQ-013 o_done  output  1  one-cycle pulse on DONE entry.

Function
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 IDLE: on an i_start rising edge (registered previous i_start low, current high) with i_stop low, next cycle SHALL be WASH.
REQ-016 On entry to WASH/RINSE/SPIN: o_remain loads that phase's *_TICKS; the tick prescaler restarts from 0.
REQ-017 Tick SHALL be a one-cycle internal strobe every TICK_DIV cycles of the active phase; each tick decrements o_remain by 1.
REQ-018 A tick with o_remain == 1 SHALL advance WASH->RINSE->SPIN->DONE on the next cycle; each phase therefore lasts exactly *_TICKS*TICK_DIV cycles.
REQ-019 DONE SHALL last exactly one cycle, with o_done=1, o_remain=0, o_pwm_duty=0, then go to IDLE.
REQ-020 Target duty: IDLE/DONE 0, WASH 1, RINSE 2, SPIN 3.
REQ-021 i_stop high in any state SHALL force IDLE next cycle, with o_pwm_duty=0, o_remain=0, o_busy=0 and no o_done pulse.
REQ-022 Stop and start in the same cycle: stop wins; state stays or becomes IDLE.
REQ-023 i_start edges while busy SHALL be ignored and SHALL not restart the phase.
REQ-024 i_start held high through DONE->IDLE SHALL NOT restart; a new rising edge is required.
REQ-025 o_remain SHALL never wrap below 0.

Reset
REQ-026 While i_rst_n is low: state IDLE, o_pwm_duty=0, o_state=0, o_remain=0, o_busy=0, o_done=0, prescaler=0, start-edge register=0.
REQ-027 Reset asserted mid-phase SHALL abort immediately, asynchronously. After release, the block SHALL wait in IDLE for a fresh i_start edge.

Configuration
REQ-028 Macro WASH_SOFT_START_EN, when defined, enables duty ramping.
- On entry to a phase, o_pwm_duty SHALL rise by 1 per tick until it reaches the target.
- Decreases, and stop, SHALL be immediate.
REQ-029 Without WASH_SOFT_START_EN, o_pwm_duty SHALL equal the state's target from the same cycle the state changes.

Verification (TICK_DIV=4, WASH=3, RINSE=2, SPIN=2)
REQ-030 Full run, macro off.
- Stimulus: i_start pulse at cycle 0.
- Response: WASH cycles 1-12 (duty 1, o_remain 3,2,1); RINSE 13-20 (duty 2); SPIN 21-28 (duty 3); DONE cycle 29 with o_done=1; IDLE at 30.
REQ-031 Abort.
- Stimulus: i_stop at cycle 15 (RINSE).
- Response: cycle 16 o_state=0, duty 0, busy 0; o_done never asserts.
REQ-032 Start rules.
- Stimulus 1: i_start held high from cycle 0 through cycle 40.
- Response 1: exactly one run, no restart after DONE.
- Stimulus 2: start and stop together.
- Response 2: stays IDLE.
REQ-033 Reset mid-operation.
- Stimulus: i_rst_n low at cycle 22 (SPIN).
- Response: all outputs 0 before the next edge; after release, stays IDLE until a new start edge.
REQ-034 Macro on.
- Stimulus: full run.
- Response: SPIN entered with duty 2, then duty 3 after the first SPIN tick; WASH duty 1 from entry.
